// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit path: parity modes, FSM state encoding and
// a parity helper usable by both TX and RX.
package uart_tx_serializer_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned MAX_DATA_BITS = 9;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ALIGN = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_PAR   = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StAlign = ST_ALIGN,
        StStart = ST_START,
        StData  = ST_DATA,
        StPar   = ST_PAR,
        StStop  = ST_STOP
    } uart_state_e;

    // Narrower words are zero-extended by the caller; zeros do not disturb the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int unsigned mode);
        logic p;
        p = 1'b0;
        if (mode == PAR_EVEN) begin
            p = ^data;
        end else if (mode == PAR_ODD) begin
            p = ~^data;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Registered rising-edge detector on the prescaler output, shared by the TX and RX paths.
module uart_baud_tick (
    input  logic clk_i,
    input  logic baud_clk_i,
    output logic tick_o
);

    logic baud_d;
    logic baud_q;

    always_comb begin
        baud_d = baud_clk_i;
    end

    // Sampled unconditionally so a level that is already high when enabled never ticks.
    always_ff @(posedge clk_i) begin
        baud_q <= baud_d;
    end

    assign tick_o = baud_clk_i & ~baud_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames one parallel word as start, data LSB first, optional
// parity and stop bits on tx, stepping on rising edges of the prescaler baud clock.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = PAR_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 src_clk,
    input  logic                 rst,
    input  logic                 baud_clk,
    output logic                 baud_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(DATA_BITS + 1);

    uart_state_e            state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [CntW-1:0]        cnt_inc;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   baud_en_q, baud_en_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   tick;
    logic                   par_bit;
    logic [MAX_DATA_BITS-1:0] data_ext;

    uart_baud_tick u_baud_tick (
        .clk_i      (src_clk),
        .baud_clk_i (baud_clk),
        .tick_o     (tick)
    );

    // Parity comes from the latched word; the shift register is consumed as bits go out.
    assign data_ext = MAX_DATA_BITS'(data_q);
    assign par_bit  = parity_bit(data_ext, PARITY);
    assign cnt_inc  = cnt_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (tx_valid && tx_ready_q) begin
                    shift_d = tx_data;
                    data_d  = tx_data;
                    cnt_d   = '0;
                    state_d = StAlign;
                end
            end
            StAlign: begin
                if (tick) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (cnt_inc == CntW'(DATA_BITS)) begin
                        cnt_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? StPar : StStop;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StPar: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    if (cnt_inc == CntW'(STOP_BITS)) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            StPar:   tx_d = par_bit;
            default: tx_d = 1'b1;
        endcase
        busy_d     = (state_d != StIdle);
        baud_en_d  = (state_d != StIdle);
        tx_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            baud_en_q  <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            baud_en_q  <= baud_en_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign baud_en  = baud_en_q;
    assign tx_ready = tx_ready_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four parameterisations, each fed by a /16 prescaler that
// freezes while disabled, checked every cycle against a bit-list frame model.
module tb_uart_tx_serializer;

    localparam int NI = 4;
    localparam int unsigned PAR_CFG  [NI] = '{0, 1, 2, 0};
    localparam int unsigned STOP_CFG [NI] = '{1, 1, 1, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0] baud_clk_w;
    wire  [NI-1:0] baud_en_w;
    wire  [NI-1:0] tx_ready_w;
    wire  [NI-1:0] tx_w;
    wire  [NI-1:0] busy_w;
    logic [NI-1:0] tx_valid_r;
    logic [7:0]    tx_data_r [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [3:0] pcnt;

        uart_tx_serializer #(
            .DATA_BITS (8),
            .PARITY    (PAR_CFG[g]),
            .STOP_BITS (STOP_CFG[g])
        ) u_dut (
            .src_clk  (clk),
            .rst      (rst),
            .baud_clk (baud_clk_w[g]),
            .baud_en  (baud_en_w[g]),
            .tx_data  (tx_data_r[g]),
            .tx_valid (tx_valid_r[g]),
            .tx_ready (tx_ready_w[g]),
            .tx       (tx_w[g]),
            .busy     (busy_w[g])
        );

        // Prescaler: period 16, holds its phase while disabled.
        always_ff @(posedge clk) begin
            if (rst) begin
                pcnt <= 4'd0;
            end else if (baud_en_w[g]) begin
                pcnt <= pcnt + 4'd1;
            end
        end
        assign baud_clk_w[g] = pcnt[3];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=0x%0h expected=0x%0h t=%0t",
                     name, inst, act, exp, $time);
        end
    endtask

    // Model: a frame is the list of line levels it must show, one entry per baud tick.
    logic          m_bits [NI][16];
    int            m_n    [NI];
    int            m_idx  [NI];
    bit            m_active [NI];
    logic [NI-1:0] m_bprev;
    logic [NI-1:0] exp_tx, exp_busy, exp_en, exp_ready;
    bit            m_valid = 1'b0;
    logic          m_tick;

    task automatic build_frame(input int i, input logic [7:0] d);
        int n;
        m_bits[i][0] = 1'b1;
        m_bits[i][1] = 1'b0;
        for (int k = 0; k < 8; k++) m_bits[i][2 + k] = d[k];
        n = 10;
        if (PAR_CFG[i] == 1) begin
            m_bits[i][n] = ^d;
            n++;
        end else if (PAR_CFG[i] == 2) begin
            m_bits[i][n] = ~^d;
            n++;
        end
        for (int s = 0; s < int'(STOP_CFG[i]); s++) begin
            m_bits[i][n] = 1'b1;
            n++;
        end
        m_n[i] = n;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_active[i] = 1'b0;
            m_idx[i]    = 0;
            m_n[i]      = 0;
        end
        m_bprev = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (m_valid) begin
                    check("cyc_tx", i, tx_w[i], exp_tx[i]);
                    check("cyc_busy", i, busy_w[i], exp_busy[i]);
                    check("cyc_baud_en", i, baud_en_w[i], exp_en[i]);
                    check("cyc_tx_ready", i, tx_ready_w[i], exp_ready[i]);
                end
                m_tick = baud_clk_w[i] & ~m_bprev[i];
                if (rst) begin
                    m_active[i]  = 1'b0;
                    exp_tx[i]    = 1'b1;
                    exp_busy[i]  = 1'b0;
                    exp_en[i]    = 1'b0;
                    exp_ready[i] = 1'b0;
                end else if (!m_active[i]) begin
                    if (exp_ready[i] && tx_valid_r[i]) begin
                        build_frame(i, tx_data_r[i]);
                        m_active[i]  = 1'b1;
                        m_idx[i]     = 0;
                        exp_tx[i]    = m_bits[i][0];
                        exp_busy[i]  = 1'b1;
                        exp_en[i]    = 1'b1;
                        exp_ready[i] = 1'b0;
                    end else begin
                        exp_tx[i]    = 1'b1;
                        exp_busy[i]  = 1'b0;
                        exp_en[i]    = 1'b0;
                        exp_ready[i] = 1'b1;
                    end
                end else if (m_tick) begin
                    m_idx[i]++;
                    if (m_idx[i] == m_n[i]) begin
                        m_active[i]  = 1'b0;
                        exp_tx[i]    = 1'b1;
                        exp_busy[i]  = 1'b0;
                        exp_en[i]    = 1'b0;
                        exp_ready[i] = 1'b1;
                    end else begin
                        exp_tx[i] = m_bits[i][m_idx[i]];
                    end
                end
                m_bprev[i] = baud_clk_w[i];
            end
            m_valid = 1'b1;
        end
    end

    task automatic wait_ready(input int i, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (tx_ready_w[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input int i, input logic [7:0] d);
        bit ok;
        @(posedge clk); #2;
        tx_valid_r[i] = 1'b1;
        tx_data_r[i]  = d;
        wait_ready(i, ok);
        @(posedge clk); #2;
        tx_valid_r[i] = 1'b0;
        check("accept_seen", i, ok, 1);
    endtask

    // Receiver: samples every cycle of each 16-cycle bit and insists it stays constant.
    task automatic rx_frame(input int i, input int nbits, output logic [15:0] bits);
        bit   found;
        bit   width_ok;
        logic v;
        found    = 1'b0;
        width_ok = 1'b1;
        bits     = '1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (tx_w[i] === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("rx_start_found", i, found, 1);
        if (found) begin
            for (int k = 0; k < nbits; k++) begin
                for (int c = 0; c < 16; c++) begin
                    if (k != 0 || c != 0) @(negedge clk);
                    v = tx_w[i];
                    if (c == 0) bits[k] = v;
                    else if (v !== bits[k]) width_ok = 1'b0;
                end
            end
            check("rx_bit_width", i, width_ok, 1);
        end
    endtask

    logic [15:0] fr_a, fr_b;
    int          blen;
    bit          ok_a, found_s;

    initial begin
        #400000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tx_valid_r = '0;
        for (int i = 0; i < NI; i++) tx_data_r[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 0, tx_w[0], 1);
        check("rst_busy", 0, busy_w[0], 0);
        check("rst_baud_en", 0, baud_en_w[0], 0);
        check("rst_tx_ready", 0, tx_ready_w[0], 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_rst", 0, tx_ready_w[0], 1);

        // 0x55, no parity, 1 stop; prescaler starts at phase 0 so busy spans 1+8+10*16.
        fork
            send(0, 8'h55);
            rx_frame(0, 10, fr_a);
            begin
                blen = 0;
                for (int t = 0; t < 400; t++) begin
                    @(negedge clk);
                    if (busy_w[0]) blen++;
                    else if (blen != 0) break;
                end
                check("busy_len", 0, blen, 169);
            end
        join
        check("f55_start", 0, fr_a[0], 0);
        check("f55_data", 0, fr_a[8:1], 8'h55);
        check("f55_stop", 0, fr_a[9], 1);

        fork
            send(1, 8'h07);
            rx_frame(1, 11, fr_a);
        join
        check("even_data", 1, fr_a[8:1], 8'h07);
        check("even_parity", 1, fr_a[9], 1);
        check("even_stop", 1, fr_a[10], 1);

        fork
            send(2, 8'h07);
            rx_frame(2, 11, fr_a);
        join
        check("odd_data", 2, fr_a[8:1], 8'h07);
        check("odd_parity", 2, fr_a[9], 0);
        check("odd_stop", 2, fr_a[10], 1);

        // Two stop bits, second word queued with tx_valid held high.
        fork
            begin
                @(posedge clk); #2;
                tx_valid_r[3] = 1'b1;
                tx_data_r[3]  = 8'hA3;
                wait_ready(3, ok_a);
                check("b2b_acc1", 3, ok_a, 1);
                @(posedge clk); #2;
                tx_data_r[3] = 8'h3C;
                @(negedge clk);
                check("b2b_ready_low", 3, tx_ready_w[3], 0);
                wait_ready(3, ok_a);
                check("b2b_acc2", 3, ok_a, 1);
                @(posedge clk); #2;
                tx_valid_r[3] = 1'b0;
                @(negedge clk);
                check("b2b_first_idle_accept", 3, tx_ready_w[3], 0);
            end
            begin
                rx_frame(3, 11, fr_a);
                rx_frame(3, 11, fr_b);
            end
        join
        check("b2b_data1", 3, fr_a[8:1], 8'hA3);
        check("b2b_stop1", 3, {fr_a[10], fr_a[9]}, 2'b11);
        check("b2b_data2", 3, fr_b[8:1], 8'h3C);
        check("b2b_stop2", 3, {fr_b[10], fr_b[9]}, 2'b11);

        // tx_valid pulse with 0xFF in the middle of a 0x00 frame.
        fork
            begin
                send(0, 8'h00);
                repeat (40) @(negedge clk);
                check("pulse_ready_pre", 0, tx_ready_w[0], 0);
                @(posedge clk); #2;
                tx_valid_r[0] = 1'b1;
                tx_data_r[0]  = 8'hFF;
                @(negedge clk);
                check("pulse_ready", 0, tx_ready_w[0], 0);
                @(posedge clk); #2;
                tx_valid_r[0] = 1'b0;
            end
            rx_frame(0, 10, fr_a);
        join
        check("pulse_data", 0, fr_a[8:1], 8'h00);
        check("pulse_stop", 0, fr_a[9], 1);
        repeat (40) @(negedge clk);
        check("pulse_no_frame", 0, busy_w[0], 0);

        // One-cycle reset during data bit 3 (a 0 bit of 0xC6).
        fork
            send(0, 8'hC6);
            begin
                found_s = 1'b0;
                for (int t = 0; t < 400; t++) begin
                    @(negedge clk);
                    if (tx_w[0] === 1'b0) begin
                        found_s = 1'b1;
                        break;
                    end
                end
                check("rstmid_start_found", 0, found_s, 1);
                repeat (72) @(negedge clk);
            end
        join
        check("rstmid_bit3_low", 0, tx_w[0], 0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_tx", 0, tx_w[0], 1);
        check("rstmid_baud_en", 0, baud_en_w[0], 0);
        check("rstmid_busy", 0, busy_w[0], 0);
        @(negedge clk);
        check("rstmid_ready", 0, tx_ready_w[0], 1);

        fork
            send(0, 8'h81);
            rx_frame(0, 10, fr_a);
        join
        check("f81_start", 0, fr_a[0], 0);
        check("f81_data", 0, fr_a[8:1], 8'h81);
        check("f81_stop", 0, fr_a[9], 1);

        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
